serial_addsub: RTL and testbench

//  Bit-serial adder/subtractor. One full-adder cell plus a carry flip-flop

---
 rtl/serial_addsub.sv | 65 ++++++
 tb/tb_serial_addsub.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, one operand bit per clock, LSB first
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b;
  logic [CW-1:0] cnt;
  logic carry, accept, last, s, c;
  assign accept = start && (state != SHIFT);
  assign last = cnt == CW'(WIDTH - 1);
  assign s = op_a[0] ^ op_b[0] ^ carry;
  assign c = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
  assign busy = state == SHIFT;
  assign done = state == DONE;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state: accept from IDLE/DONE, walk SHIFT for WIDTH edges, DONE lasts one cycle
  always_comb begin
    state_nxt = IDLE;
    state_nxt = accept ? SHIFT : (state != SHIFT) ? IDLE : last ? DONE : SHIFT;
  end
  // datapath: op_a doubles as the result shift register, sum bits enter at its MSB
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      op_a <= a;
      op_b <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      cnt <= '0;
    end else if (state == SHIFT) begin
      op_a <= {s, op_a[WIDTH-1:1]};
      op_b <= op_b >> 1;
      carry <= c;
      cnt <= cnt + 1'b1;
      if (last) begin
        sum <= {s, op_a[WIDTH-1:1]};
        cout <= c;
        overflow <= c ^ carry;
      end
    end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: randomized scoreboard bench for serial_addsub against an arithmetic model
module tb_serial_addsub;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, start = 0, cin = 0, sub = 0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, cout, overflow;
  logic [W-1:0] sum;
  typedef struct {
    logic [W-1:0] sum;
    logic cout;
    logic ov;
    int cyc;
  } exp_t;
  exp_t q[$];
  exp_t held = '{'0, 1'b0, 1'b0, 0};
  exp_t e;
  int cyc = 0, checks = 0, errors = 0;
  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic, input logic is);
    exp_t r;
    int sa, sb, sr;
    logic [W:0] u;
    sa = $signed(ia);
    sb = $signed(ib);
    if (is) begin
      u = {1'b0, ia} - {1'b0, ib};
      r.cout = ia >= ib;
      sr = sa - sb;
    end else begin
      u = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
      r.cout = u[W];
      sr = sa + sb + int'(ic);
    end
    r.sum = u[W-1:0];
    r.ov = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
    r.cyc = 0;
    return r;
  endfunction
  // monitor: pop expected result on every done pulse, otherwise outputs must hold
  always @(negedge clk) begin
    if (!rst_n) held = '{'0, 1'b0, 1'b0, 0};
    else begin
      chk("busy_done_excl", {31'b0, busy & done}, 0);
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("sum", {24'b0, sum}, {24'b0, e.sum});
          chk("cout", {31'b0, cout}, {31'b0, e.cout});
          chk("overflow", {31'b0, overflow}, {31'b0, e.ov});
          chk("done_cycle", cyc, e.cyc);
          held = e;
        end
      end else begin
        chk("sum_hold", {24'b0, sum}, {24'b0, held.sum});
        chk("cout_hold", {31'b0, cout}, {31'b0, held.cout});
        chk("ov_hold", {31'b0, overflow}, {31'b0, held.ov});
      end
    end
  end
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic, input logic is, input bit noise);
    exp_t x;
    int n;
    a = ia;
    b = ib;
    cin = ic;
    sub = is;
    start = 1;
    x = model(ia, ib, ic, is);
    x.cyc = cyc + 1 + W;
    q.push_back(x);
    @(posedge clk);
    @(negedge clk);
    start = 0;
    n = 0;
    while (busy && n < W + 2) begin
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      if (noise) start = 1'($urandom);
      @(negedge clk);
      n++;
    end
    start = 0;
    chk("busy_timeout", {31'b0, busy}, 0);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_done"}, {31'b0, done}, 0);
    chk({tag, "_sum"}, {24'b0, sum}, 0);
    chk({tag, "_cout"}, {31'b0, cout}, 0);
    chk({tag, "_ov"}, {31'b0, overflow}, 0);
  endtask
  initial begin
    #1 chk_zero("reset");
    @(negedge clk);
    rst_n = 1;
    issue(8'hFF, 8'h01, 0, 0, 0);
    idle(1);
    issue(8'h7F, 8'h01, 0, 0, 0);
    issue(8'h80, 8'h01, 0, 1, 0);
    idle(2);
    issue(8'h05, 8'h07, 0, 1, 0);
    issue(8'h12, 8'h34, 1, 0, 0);
    idle(1);
    issue(8'h3C, 8'hA5, 1, 0, 1);
    issue(8'h90, 8'h20, 0, 1, 1);
    idle(1);
    for (int i = 0; i < 5; i++) issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0);
    a = 8'h55;
    b = 8'h66;
    start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1 chk_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1;
    issue(8'h40, 8'h40, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      idle($urandom_range(0, 2));
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    idle(W + 3);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
